// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter plus IF/ID pipeline register for the MIPS
// pipeline. Drives PC+4 back to the next-PC mux. Addresses an
// asynchronous-read instruction memory and hands the fetched word and PC+4
// to decode. Handles load-use stalls, branch/jump flushes and HALT detection.
//
// Optional build macro STEP_MODE_EN adds single-step support. A rising edge on
// i_step advances the stage once while i_enable is low. Without the macro,
// i_step is ignored and no edge-detect register is built.
module pc_fetch_stage #(
  parameter int unsigned      NBITS       = 32,
  parameter int unsigned      IMEM_AW     = 10,
  parameter logic [NBITS-1:0] RESET_PC    = '0,
  parameter logic [NBITS-1:0] HALT_OPCODE = '1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NBITS-1:0]   i_next_pc,
  input  logic               i_step,
  input  logic [NBITS-1:0]   i_imem_rdata,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [NBITS-1:0]   o_pc,
  output logic [NBITS-1:0]   o_pc_plus4,
  output logic [NBITS-1:0]   o_ifid_instr,
  output logic [NBITS-1:0]   o_ifid_pc4,
  output logic               o_ifid_valid,
  output logic               o_halted
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [NBITS-1:0] instr_q, instr_d;
  logic [NBITS-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic             halted_q;

  logic [NBITS-1:0] pc_plus4;
  logic             is_halt_word;
  logic             step_ev;
  logic             en_eff;

  // PC+4 wraps naturally modulo 2^NBITS; the low two PC bits are never inspected.
  assign pc_plus4     = pc_q + NBITS'(4);
  assign is_halt_word = (i_imem_rdata == HALT_OPCODE);

`ifdef STEP_MODE_EN
  logic step_prev_q;
  logic step_pend_q, step_pend_d;
  logic step_edge;

  // A held-high step yields one edge. An edge seen while stalled stays
  // pending until the stall clears. A flush on that cycle consumes the step.
  assign step_edge   = i_step & ~step_prev_q;
  assign step_ev     = step_edge | step_pend_q;
  assign step_pend_d = step_ev & i_stall & ~i_flush;

  // Step edge detector and pending-step flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_prev_q <= i_step;
      step_pend_q <= step_pend_d;
    end
  end
`else
  logic unused_step;
  assign unused_step = i_step;
  assign step_ev     = 1'b0;
`endif

  // A step event behaves like a one-cycle enable, including for flushes.
  assign en_eff = i_enable | step_ev;

  // Next-state selection for PC, IF/ID and the RUN/HALT state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      ST_RUN: begin
        if (i_flush && en_eff) begin
          // Flush wins over stall: redirect and squash IF/ID.
          pc_d    = i_next_pc;
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
        end else if (en_eff && !i_stall) begin
          instr_d = i_imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (is_halt_word) begin
            // Halt word goes to decode, but the PC freezes on it.
            state_d = ST_HALT;
          end else begin
            pc_d = i_next_pc;
          end
        end
      end
      ST_HALT: begin
        if (en_eff) begin
          instr_d = '0;
          pc4_d   = '0;
          valid_d = 1'b0;
          if (i_flush) begin
            // The halt word was fetched on a mispredicted path; resume.
            pc_d    = i_next_pc;
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, PC and IF/ID registers; o_halted is registered alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc4_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign o_imem_addr  = pc_q[IMEM_AW+1:2];
  assign o_pc         = pc_q;
  assign o_pc_plus4   = pc_plus4;
  assign o_ifid_instr = instr_q;
  assign o_ifid_pc4   = pc4_q;
  assign o_ifid_valid = valid_q;
  assign o_halted     = halted_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Testbench for pc_fetch_stage: directed scenarios followed by randomized
// stimulus, checked each cycle against a behavioural model of the fetch stage.
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        stall;
  logic        flush;
  logic [31:0] nxt;
  logic        step;
  logic [31:0] rdata;
  logic [9:0]  imem_addr;
  logic [31:0] pc, pc_plus4, ifid_instr, ifid_pc4;
  logic        ifid_valid, halted;

  logic [31:0] imem [0:1023];

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt, m_sprev, m_pend;

  pc_fetch_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_next_pc    (nxt),
    .i_step       (step),
    .i_imem_rdata (rdata),
    .o_imem_addr  (imem_addr),
    .o_pc         (pc),
    .o_pc_plus4   (pc_plus4),
    .o_ifid_instr (ifid_instr),
    .o_ifid_pc4   (ifid_pc4),
    .o_ifid_valid (ifid_valid),
    .o_halted     (halted)
  );

  assign rdata = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_halt = 1'b0; m_sprev = 1'b0; m_pend = 1'b0;
  endtask

  // One clock of the fetch stage, computed from the current inputs.
  task automatic model_next();
    logic [31:0] word;
    logic        sev;
    logic        ee;
    word = imem[m_pc[11:2]];
    sev  = 1'b0;
`ifdef STEP_MODE_EN
    sev     = (step && !m_sprev) || m_pend;
    m_pend  = sev && stall && !flush;
    m_sprev = step;
`endif
    ee = en || sev;
    if (!m_halt) begin
      if (flush && ee) begin
        m_pc = nxt; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (ee && !stall) begin
        m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
        if (word == 32'hFFFF_FFFF) m_halt = 1'b1;
        else m_pc = nxt;
      end
    end else if (ee) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (flush) begin
        m_pc = nxt; m_halt = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"},    pc,                 m_pc);
    chk({tag, ".pc4o"},  pc_plus4,           m_pc + 32'd4);
    chk({tag, ".addr"},  {22'h0, imem_addr}, {22'h0, m_pc[11:2]});
    chk({tag, ".instr"}, ifid_instr,         m_instr);
    chk({tag, ".ifpc4"}, ifid_pc4,           m_pc4);
    chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
    chk({tag, ".halt"},  {31'h0, halted},     {31'h0, m_halt});
  endtask

  task automatic tick(input string tag);
    model_next();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic e, input logic s, input logic f, input logic [31:0] n);
    en = e; stall = s; flush = f; nxt = n;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] exp_step_pc;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      imem[i] = w;
    end
    imem[0] = 32'h2001_0005;
    imem[4] = 32'hFFFF_FFFF;

    rst_n = 1'b0;
    step  = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("rst");

    // Straight-line fetch from reset.
    rst_n = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    tick("run1");
    chk("first_pc",    pc,         32'd4);
    chk("first_instr", ifid_instr, 32'h2001_0005);
    chk("first_pc4",   ifid_pc4,   32'd4);
    chk("first_valid", {31'h0, ifid_valid}, 32'd1);
    set_in(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    tick("run2");

    // Two stalled cycles at pc=8.
    set_in(1'b1, 1'b1, 1'b0, m_pc + 32'd4);
    tick("stall1");
    tick("stall2");
    chk("stall_pc",    pc,         32'd8);
    chk("stall_instr", ifid_instr, imem[1]);
    set_in(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    tick("resume");
    chk("resume_pc", pc, 32'd12);

    // Flush takes priority over stall.
    set_in(1'b1, 1'b1, 1'b1, 32'h40);
    tick("flush");
    chk("flush_pc",    pc,         32'h40);
    chk("flush_instr", ifid_instr, 32'h0);
    chk("flush_valid", {31'h0, ifid_valid}, 32'd0);

    // Fetch the halt word at pc=16, then leave HALT by a flush.
    set_in(1'b1, 1'b0, 1'b1, 32'd16);
    tick("to16");
    set_in(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    tick("haltcap");
    chk("halt_flag",  {31'h0, halted}, 32'd1);
    chk("halt_pc",    pc,              32'd16);
    chk("halt_instr", ifid_instr,      32'hFFFF_FFFF);
    tick("halted2");
    chk("halt_hold_pc", pc, 32'd16);
    chk("halt_nop_vld", {31'h0, ifid_valid}, 32'd0);
    set_in(1'b1, 1'b0, 1'b1, 32'h80);
    tick("unhalt");
    chk("unhalt_flag", {31'h0, halted}, 32'd0);
    chk("unhalt_pc",   pc,              32'h80);

    // PC+4 wraps at the top of the address space.
    set_in(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick("towrap");
    chk("wrap_pc4", pc_plus4, 32'h0);
    set_in(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    tick("wrap");
    chk("wrap_pc", pc, 32'h0);

    // Asynchronous reset between clock edges.
    set_in(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
    tick("prerst");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_pc",    pc,         32'h0);
    chk("async_valid", {31'h0, ifid_valid}, 32'd0);
    chk("async_instr", ifid_instr, 32'h0);
    @(posedge clk);
    #1;
    compare_all("inrst");
    rst_n = 1'b1;

    // Step held high for five cycles with the stage disabled.
    set_in(1'b0, 1'b0, 1'b0, 32'd4);
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt = m_pc + 32'd4;
      tick("step");
    end
`ifdef STEP_MODE_EN
    exp_step_pc = 32'd4;
`else
    exp_step_pc = 32'd0;
`endif
    chk("step_pc", pc, exp_step_pc);
    step = 1'b0;

    // Randomized phase with occasional halt words in memory.
    for (int i = 0; i < 1024; i++)
      if (($urandom & 15) == 0) imem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 9) < 8);
      stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) < 1);
      step  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0, 1: nxt = m_pc + 32'd4;
        2:    nxt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        default: nxt = $urandom & 32'h0000_0FFF;
      endcase
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program counter register and IF/ID pipeline register for the MIPS pipeline.
- Consumes the next-PC selected by Mux_PC (o_pc) and drives PC+4 back to Mux_PC's i_sumador_pc4.
- Addresses the asynchronous-read instruction memory and presents fetched instruction plus PC+4 to the decode stage.
- Handles hazard stall, branch/jump flush and HALT detection for the debug unit.

Parameters:
- NBITS, 32, datapath/PC width.
- IMEM_AW, 10, instruction memory word-address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- HALT_OPCODE, 32'hFFFF_FFFF, instruction word that halts fetch.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset.
- i_enable  in  1  run enable from debug unit; low freezes the stage.
- i_stall  in  1  load-use stall from hazard unit; holds PC and IF/ID.
- i_flush  in  1  branch/jump taken; squashes the IF/ID contents.
- i_next_pc  in  NBITS  next PC from Mux_PC.
- i_step  in  1  single-step request (see Optional Feature).
- i_imem_rdata  in  NBITS  instruction word at o_imem_addr, combinational.
- o_imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2].
- o_pc  out  NBITS  current PC register.
- o_pc_plus4  out  NBITS  pc + 4, combinational, to Mux_PC.
- o_ifid_instr  out  NBITS  registered instruction to decode.
- o_ifid_pc4  out  NBITS  registered PC+4 to decode.
- o_ifid_valid  out  1  IF/ID holds a real instruction.
- o_halted  out  1  high in HALT state.

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC.
  - o_ifid_instr = 0 (NOP), o_ifid_pc4 = 0, o_ifid_valid = 0.
  - State = RUN, o_halted = 0.
- Arithmetic:
  - o_pc_plus4 = pc + 4, modulo 2^NBITS; 32'hFFFF_FFFC wraps to 0.
  - Low two PC bits are never checked.
- Advance condition: adv = state==RUN && i_enable && !i_stall.
- RUN state, all updates on one clock edge:
  - i_flush=1 (priority over stall, requires i_enable): pc <= i_next_pc; IF/ID <= NOP, valid 0.
  - adv && i_imem_rdata != HALT_OPCODE: pc <= i_next_pc; instr <= i_imem_rdata; pc4 <= pc+4; valid <= 1.
  - adv && i_imem_rdata == HALT_OPCODE: IF/ID captures the halt word with valid 1; pc holds; state -> HALT.
  - Otherwise (stall or !i_enable): pc and IF/ID hold all values.
- Latency: instruction at PC appears on o_ifid_instr one cycle after it is addressed.
- HALT state:
  - o_halted = 1; pc holds.
  - Each enabled cycle loads NOP with valid 0 into IF/ID.
  - If i_flush && i_enable: the halt was speculative; pc <= i_next_pc, IF/ID <= NOP, state -> RUN.
  - Otherwise HALT is exited only by reset.
- Reset asserted mid-operation overrides everything immediately; no partial update is retained.

Optional Feature:
- Macro: STEP_MODE_EN.
- Defined:
  - i_step is rising-edge detected by an internal register.
  - adv additionally becomes true for one cycle on a detected edge while i_enable=0 (still gated by state==RUN and !i_stall).
  - A step taken while stalled is held pending until the stall clears, then consumed.
  - i_step held high produces exactly one advance.
  - i_flush is honoured on a step cycle as if i_enable were high.
- Undefined: i_step is ignored and no edge register is built.

Test Plan:
- Reset release, i_enable=1, i_next_pc=o_pc_plus4, imem returns 32'h2001_0005 at address 0 -> cycle 1: o_pc=4, o_ifid_instr=32'h2001_0005, o_ifid_pc4=4, o_ifid_valid=1.
- i_stall=1 for 2 cycles at pc=8 -> o_pc stays 8 and IF/ID unchanged; resumes at 12 after release.
- i_flush=1 with i_stall=1 and i_next_pc=32'h40 -> next cycle o_pc=32'h40, o_ifid_instr=0, o_ifid_valid=0.
- imem returns 32'hFFFF_FFFF at pc=16 -> o_halted=1, o_pc stays 16, following IF/ID valid=0; i_flush with i_next_pc=32'h80 -> RUN, o_pc=32'h80.
- pc=32'hFFFF_FFFC -> o_pc_plus4=0; async reset asserted mid-clock -> o_pc=RESET_PC immediately.
- With STEP_MODE_EN, i_enable=0, i_step held high 5 cycles -> exactly one PC advance (0 to 4); without the macro -> PC stays 0.
